// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared constants and the bank-flag update helper for the ping-pong buffer controller.
package pingpong_buf_ctrl_pkg;

  localparam int unsigned PP_BANK_W     = 1;
  localparam int unsigned PP_FIFO_DEPTH = 2;

  // Clear and set may hit different banks in the same cycle; both are applied.
  function automatic logic [1:0] next_bank_full(
    input logic [1:0] cur,
    input logic       set_en,
    input logic       set_idx,
    input logic       clr_en,
    input logic       clr_idx
  );
    logic [1:0] nxt;
    nxt = cur;
    if (clr_en) nxt[clr_idx] = 1'b0;
    if (set_en) nxt[set_idx] = 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_ram.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
module com_simple_dual_port_ram #(
  parameter int WIDTH  = 36,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_din,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] b_dout_q;

  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_addr] <= a_din;
    if (b_re) b_dout_q <= mem_q[b_addr];
  end

  assign b_dout = b_dout_q;

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the reader
// drains the other through a 2-entry output FIFO fed by a 1-cycle-latency RAM.
module pingpong_buf_ctrl
  import pingpong_buf_ctrl_pkg::*;
#(
  parameter int WIDTH    = 36,
  parameter int ADDR_BIT = 9,
  parameter int DEPTH    = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  input  logic             rd_ready,
  output logic [1:0]       bank_full
);

  localparam int BANK_W     = PP_BANK_W;
  localparam int FIFO_DEPTH = PP_FIFO_DEPTH;
  localparam int LEN_W      = ADDR_BIT + 1;
  localparam logic [ADDR_BIT-1:0] LAST_OFF = ADDR_BIT'(DEPTH - 1);

  logic [BANK_W-1:0]   wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic [LEN_W-1:0]    len_q [2];
  logic [LEN_W-1:0]    len_d [2];
  logic                in_flight_q, in_flight_d;
  logic                in_flight_last_q, in_flight_last_d;
  logic [1:0]          out_count_q, out_count_d;
  logic [WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [WIDTH-1:0]    fifo_data_d [FIFO_DEPTH];
  logic                fifo_last_q [FIFO_DEPTH];
  logic                fifo_last_d [FIFO_DEPTH];

  logic             wr_fire;
  logic             wr_end;
  logic             pop;
  logic [2:0]       occupancy;
  logic             rd_issue;
  logic             rd_issue_last;
  logic [1:0]       after_pop;
  logic [WIDTH-1:0] ram_rdata;

  assign wr_ready  = !bank_full_q[wr_bank_q];
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_end    = wr_fire && (wr_last || (wr_ptr_q == LAST_OFF));
  assign pop       = (out_count_q != 2'd0) && rd_ready;
  assign after_pop = out_count_q - {1'b0, pop};

  // A word leaving the FIFO this cycle frees its slot for the read issued now,
  // which keeps the output streaming at one word per cycle.
  assign occupancy     = {1'b0, out_count_q} + {2'b00, in_flight_q} - {2'b00, pop};
  assign rd_issue      = bank_full_q[rd_bank_q] && (occupancy < 3'(FIFO_DEPTH));
  assign rd_issue_last = rd_issue && (({1'b0, rd_ptr_q} + LEN_W'(1)) == len_q[rd_bank_q]);

  assign rd_valid  = (out_count_q != 2'd0);
  assign rd_data   = rd_valid ? fifo_data_q[0] : '0;
  assign rd_last   = rd_valid && fifo_last_q[0];
  assign bank_full = bank_full_q;

  always_comb begin
    wr_bank_d        = wr_bank_q;
    rd_bank_d        = rd_bank_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    len_d            = len_q;
    fifo_data_d      = fifo_data_q;
    fifo_last_d      = fifo_last_q;
    in_flight_d      = rd_issue;
    in_flight_last_d = rd_issue_last;
    out_count_d      = out_count_q + {1'b0, in_flight_q} - {1'b0, pop};
    bank_full_d      = next_bank_full(bank_full_q, wr_end, wr_bank_q[0], rd_issue_last, rd_bank_q[0]);

    if (wr_end) begin
      len_d[wr_bank_q] = {1'b0, wr_ptr_q} + LEN_W'(1);
      wr_bank_d        = ~wr_bank_q;
      wr_ptr_d         = '0;
    end else if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + ADDR_BIT'(1);
    end

    if (rd_issue_last) begin
      rd_bank_d = ~rd_bank_q;
      rd_ptr_d  = '0;
    end else if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ADDR_BIT'(1);
    end

    // Head shifts out first; the returning RAM word lands behind whatever remains.
    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_last_d[0] = fifo_last_q[1];
    end
    if (in_flight_q) begin
      fifo_data_d[after_pop[0]] = ram_rdata;
      fifo_last_d[after_pop[0]] = in_flight_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q        <= '0;
      rd_bank_q        <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      bank_full_q      <= 2'b00;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      out_count_q      <= 2'd0;
      for (int i = 0; i < 2; i++) len_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      wr_bank_q        <= wr_bank_d;
      rd_bank_q        <= rd_bank_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      bank_full_q      <= bank_full_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
      out_count_q      <= out_count_d;
      len_q            <= len_d;
      fifo_data_q      <= fifo_data_d;
      fifo_last_q      <= fifo_last_d;
    end
  end

  com_simple_dual_port_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_BIT + 1),
    .DEPTH  (2 * DEPTH)
  ) u_ram (
    .clk    (clk),
    .a_we   (wr_fire && !rst),
    .a_addr ({wr_bank_q, wr_ptr_q}),
    .a_din  (wr_data),
    .b_re   (rd_issue),
    .b_addr ({rd_bank_q, rd_ptr_q}),
    .b_dout (ram_rdata)
  );

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed scoreboard bench for pingpong_buf_ctrl with a small geometry (8 words per bank).
module tb_pingpong_buf_ctrl;

  localparam int WIDTH    = 8;
  localparam int ADDR_BIT = 3;
  localparam int DEPTH    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_last;
  logic             wr_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;
  logic             rd_ready;
  logic [1:0]       bank_full;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected read stream as {last, data}, appended when a write is accepted.
  logic [WIDTH:0] exp_q [$];
  logic [WIDTH:0] mon_head;
  int             model_wr_off = 0;
  logic           mon_en = 1'b0;

  always #5 clk = ~clk;

  pingpong_buf_ctrl #(
    .WIDTH    (WIDTH),
    .ADDR_BIT (ADDR_BIT),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_ready  (rd_ready),
    .bank_full (bank_full)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every valid output cycle must show the oldest outstanding word, stalled or not.
  always @(negedge clk) begin
    if (!rst && mon_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_word", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_head = exp_q[0];
        checkOutput("rd_data", 32'(rd_data), 32'(mon_head[WIDTH-1:0]));
        checkOutput("rd_last", 32'(rd_last), 32'(mon_head[WIDTH]));
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last);
    int   waited;
    logic exp_last;
    waited   = 0;
    wr_valid = 1'b1;
    wr_data  = data;
    wr_last  = last;
    @(negedge clk);
    while (!wr_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!wr_ready) begin
      checkOutput("wr_accept_timeout", 32'(wr_ready), 32'd1);
      wr_valid = 1'b0;
      return;
    end
    exp_last     = last || (model_wr_off == DEPTH - 1);
    exp_q.push_back({exp_last, data});
    model_wr_off = exp_last ? 0 : model_wr_off + 1;
    tick();
  endtask

  task automatic writeFrame(input logic [WIDTH-1:0] base, input int n, input logic with_last);
    for (int i = 0; i < n; i++) applyStimulus(base + WIDTH'(i), with_last && (i == n - 1));
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_bank_full", 32'(bank_full), 32'h0);
    checkOutput("reset_rd_valid",  32'(rd_valid),  32'h0);
    checkOutput("reset_rd_last",   32'(rd_last),   32'h0);
    checkOutput("reset_rd_data",   32'(rd_data),   32'h0);
    checkOutput("reset_wr_ready",  32'(wr_ready),  32'h1);
    mon_en = 1'b1;

    // 4-word frame, latency and back-to-back readout.
    rd_ready = 1'b1;
    writeFrame(8'h10, 4, 1'b1);
    checkOutput("s1_bank_full", 32'(bank_full), 32'h1);
    @(negedge clk) checkOutput("s1_lat_cycle1", 32'(rd_valid), 32'h0);
    @(negedge clk) checkOutput("s1_lat_cycle2", 32'(rd_valid), 32'h0);
    @(negedge clk) checkOutput("s1_first_valid", 32'(rd_valid), 32'h1);
    for (int i = 1; i < 4; i++) @(negedge clk) checkOutput("s1_back_to_back", 32'(rd_valid), 32'h1);
    drain("s1_drain");
    checkOutput("s1_banks_empty", 32'(bank_full), 32'h0);

    // Forced frame end at the last offset of the bank.
    writeFrame(8'h20, 8, 1'b0);
    checkOutput("s2_bank_full", 32'(bank_full), 32'h2);
    drain("s2_drain");

    // Both banks full with the reader stalled: writer must be held off.
    rd_ready = 1'b0;
    writeFrame(8'h30, 3, 1'b1);
    writeFrame(8'h40, 3, 1'b1);
    checkOutput("s3_bank_full", 32'(bank_full), 32'h3);
    checkOutput("s3_wr_ready_low", 32'(wr_ready), 32'h0);
    wr_valid = 1'b1;
    wr_data  = 8'h50;
    wr_last  = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk) checkOutput("s3_blocked", 32'(wr_ready), 32'h0);
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    checkOutput("s3_bank_full_hold", 32'(bank_full), 32'h3);
    rd_ready = 1'b1;
    c = 0;
    while (!wr_ready && c < 20) begin
      tick();
      c++;
    end
    checkOutput("s3_wr_ready_return", 32'(wr_ready), 32'h1);
    drain("s3_drain");

    // Consumer alternating ready every cycle.
    rd_ready = 1'b0;
    writeFrame(8'h60, 5, 1'b1);
    for (int i = 0; i < 24; i++) begin
      tick();
      rd_ready = ~rd_ready;
    end
    rd_ready = 1'b1;
    drain("s4_drain");

    // 1-word frame accepted on the edge the reader issues the other bank's last read.
    writeFrame(8'h70, 3, 1'b1);
    tick();
    tick();
    writeFrame(8'hAA, 1, 1'b1);
    checkOutput("s5_flags_swap", 32'(bank_full), 32'h1);
    drain("s5_drain");

    // Reset mid-frame with a full bank pending.
    rd_ready = 1'b0;
    writeFrame(8'h80, 2, 1'b1);
    writeFrame(8'h90, 3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_wr_off = 0;
    checkOutput("s6_bank_full", 32'(bank_full), 32'h0);
    checkOutput("s6_rd_valid",  32'(rd_valid),  32'h0);
    checkOutput("s6_rd_last",   32'(rd_last),   32'h0);
    checkOutput("s6_rd_data",   32'(rd_data),   32'h0);
    checkOutput("s6_wr_ready",  32'(wr_ready),  32'h1);
    rd_ready = 1'b1;
    writeFrame(8'hB0, 2, 1'b1);
    drain("s6_drain");
    repeat (3) tick();
    checkOutput("final_idle", 32'(rd_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
